// File: rtl/latch_array_ctrl.sv
// latch_array_ctrl: sequencer for the 8x32 pulse-program latch array.
// A write FSM gives host writes latch-safe timing. The registered address and
// data settle one cycle before a single-cycle strobe, and they are held for one
// cycle after it. A read FSM streams words start_addr..end_addr to the pulse
// transmitter. Playback can repeat when looping is enabled.
// Optional feature macro: PROG_LOOP_EN (defined = loop_count honoured).
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that edge. Ready may depend combinationally on state, never on
// valid.
module latch_array_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int LOOP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [LOOP_W-1:0] loop_count,
  output logic              busy,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [DATA_W-1:0] word_data,
  output logic              word_last,
  output logic [ADDR_W-1:0] la_read_address,
  input  logic [DATA_W-1:0] la_rdata,
  output logic              la_write,
  output logic [ADDR_W-1:0] la_write_address,
  output logic [DATA_W-1:0] la_wdata,
  output logic [1:0]        wr_state_dbg,
  output logic [1:0]        rd_state_dbg
);

  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_PRESENT} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic              host_accept;
  logic              hazard;
  logic              last_pass;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              word_valid_next;
  logic [DATA_W-1:0] word_data_next;

`ifdef PROG_LOOP_EN
  logic [LOOP_W-1:0] loops, loops_next;
  assign last_pass = (loops == '0);
`else
  // loop_count has no function in this build.
  logic unused_loop_count;
  assign unused_loop_count = ^loop_count;
  assign last_pass = 1'b1;
`endif

  assign host_wr_ready   = (w_state == W_IDLE) & ~rst;
  assign host_accept     = host_wr_valid & host_wr_ready;
  // Only the word being fetched is protected; the write register is already
  // loaded in SETUP, so comparing it covers the whole SETUP..HOLD window.
  assign hazard          = (w_state != W_IDLE) && (la_write_address == ptr);
  assign la_read_address = ptr;
  assign busy            = (r_state != R_IDLE);
  assign word_last       = word_valid & (ptr == end_addr) & last_pass;
  assign wr_state_dbg    = w_state;
  assign rd_state_dbg    = r_state;

  // Write FSM next state: a fixed 4-cycle walk once a request is accepted.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:   if (host_accept) w_next = W_SETUP;
      W_SETUP:  w_next = W_STROBE;
      W_STROBE: w_next = W_HOLD;
      W_HOLD:   w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
  end

  // Write FSM registers. The strobe is a flop, so the array sees a glitch-free pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state          <= W_IDLE;
      la_write         <= 1'b0;
      la_write_address <= '0;
      la_wdata         <= '0;
    end else begin
      w_state  <= w_next;
      la_write <= (w_next == W_STROBE);
      if (host_accept) begin
        la_write_address <= host_wr_addr;
        la_wdata         <= host_wr_data;
      end
    end
  end

  // Read FSM next state and datapath; stop overrides everything else.
  always_comb begin
    r_next          = r_state;
    ptr_next        = ptr;
    word_valid_next = word_valid;
    word_data_next  = word_data;
`ifdef PROG_LOOP_EN
    loops_next      = loops;
`endif
    if (stop) begin
      r_next          = R_IDLE;
      word_valid_next = 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (start) begin
            ptr_next = start_addr;
`ifdef PROG_LOOP_EN
            loops_next = loop_count;
`endif
            r_next   = R_FETCH;
          end
        end
        R_FETCH: begin
          if (!hazard) begin
            word_data_next  = la_rdata;
            word_valid_next = 1'b1;
            r_next          = R_PRESENT;
          end
        end
        R_PRESENT: begin
          if (word_ready) begin
            // Drop valid during the refetch so a word is never consumed twice.
            word_valid_next = 1'b0;
            if (ptr != end_addr) begin
              ptr_next = ptr + ADDR_W'(1);
              r_next   = R_FETCH;
            end else if (!last_pass) begin
`ifdef PROG_LOOP_EN
              loops_next = loops - LOOP_W'(1);
`endif
              ptr_next   = start_addr;
              r_next     = R_FETCH;
            end else begin
              r_next = R_IDLE;
            end
          end
        end
        default: begin
          r_next          = R_IDLE;
          word_valid_next = 1'b0;
        end
      endcase
    end
  end

  // Read FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= R_IDLE;
      ptr        <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
`ifdef PROG_LOOP_EN
      loops      <= '0;
`endif
    end else begin
      r_state    <= r_next;
      ptr        <= ptr_next;
      word_valid <= word_valid_next;
      word_data  <= word_data_next;
`ifdef PROG_LOOP_EN
      loops      <= loops_next;
`endif
    end
  end

endmodule

// File: tb/tb_latch_array_ctrl.sv
// Testbench for latch_array_ctrl: directed steps with a behavioural latch array.
module tb_latch_array_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [2:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic        start;
  logic        stop;
  logic [2:0]  start_addr;
  logic [2:0]  end_addr;
  logic [7:0]  loop_count;
  logic        busy;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_last;
  logic [2:0]  la_read_address;
  logic [31:0] la_rdata;
  logic        la_write;
  logic [2:0]  la_write_address;
  logic [31:0] la_wdata;
  logic [1:0]  wr_state_dbg;
  logic [1:0]  rd_state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic        last_q[$];
  logic [31:0] mem[8];

  // Clock / reset block.
  always #5 clk = ~clk;

  latch_array_ctrl dut (
    .clk(clk), .rst(rst),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .start(start), .stop(stop), .start_addr(start_addr), .end_addr(end_addr),
    .loop_count(loop_count), .busy(busy),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .word_last(word_last),
    .la_read_address(la_read_address), .la_rdata(la_rdata),
    .la_write(la_write), .la_write_address(la_write_address), .la_wdata(la_wdata),
    .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // Latch array model: word captured while the strobe is high, read is combinational.
  always @(posedge clk) begin
    if (la_write) mem[la_write_address] <= la_wdata;
  end
  assign la_rdata = mem[la_read_address];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: got %h, need %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: got %b, need %b", tag, obs, exp_v);
    end
  endtask

  // Driver: one host write, waiting (bounded) for ready and for the write to retire.
  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    int n;
    n = 0;
    host_wr_valid = 1'b1;
    host_wr_addr  = a;
    host_wr_data  = d;
    #1;
    while (!host_wr_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("host_write_timeout", 32'(n), 32'd0);
    tick();
    host_wr_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // Scoreboard: pop an expected word on every transmitter handshake.
  task automatic collect(input int budget);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      if (word_valid && word_ready) begin
        chk("stream_data", word_data, exp_q[0]);
        chk1("stream_last", word_last, last_q[0]);
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      tick();
      c++;
    end
    if (exp_q.size() != 0) chk("stream_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    start = 1'b0; stop = 1'b0; start_addr = '0; end_addr = '0; loop_count = '0;
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset state.
    tick(); tick();
    chk1("rst_ready", host_wr_ready, 1'b0);
    chk1("rst_la_write", la_write, 1'b0);
    chk1("rst_word_valid", word_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_word_last", word_last, 1'b0);
    chk("rst_word_data", word_data, 32'd0);
    chk("rst_rd_addr", 32'(la_read_address), 32'd0);
    chk("rst_wr_addr", 32'(la_write_address), 32'd0);
    chk("rst_wdata", la_wdata, 32'd0);
    rst = 1'b0;
    tick();
    chk1("post_rst_ready", host_wr_ready, 1'b1);

    // Write addr 5: setup, single strobe, hold, ready low for 3 cycles.
    host_wr_valid = 1'b1; host_wr_addr = 3'd5; host_wr_data = 32'hDEADBEEF;
    #1;
    chk1("wr_ready_idle", host_wr_ready, 1'b1);
    tick();
    host_wr_valid = 1'b0; host_wr_addr = 3'd0; host_wr_data = 32'h0;
    chk("wr_setup_addr", 32'(la_write_address), 32'd5);
    chk("wr_setup_data", la_wdata, 32'hDEADBEEF);
    chk1("wr_setup_strobe", la_write, 1'b0);
    chk1("wr_setup_ready", host_wr_ready, 1'b0);
    chk("wr_setup_state", 32'(wr_state_dbg), 32'd1);
    tick();
    chk1("wr_strobe", la_write, 1'b1);
    chk("wr_strobe_addr", 32'(la_write_address), 32'd5);
    chk("wr_strobe_data", la_wdata, 32'hDEADBEEF);
    chk1("wr_strobe_ready", host_wr_ready, 1'b0);
    tick();
    chk1("wr_hold_strobe", la_write, 1'b0);
    chk("wr_hold_addr", 32'(la_write_address), 32'd5);
    chk("wr_hold_data", la_wdata, 32'hDEADBEEF);
    chk1("wr_hold_ready", host_wr_ready, 1'b0);
    chk("wr_array_word", mem[5], 32'hDEADBEEF);
    tick();
    chk1("wr_done_ready", host_wr_ready, 1'b1);
    chk1("wr_done_strobe", la_write, 1'b0);

    // Preload words 0..7 = 0x100+i.
    for (int i = 0; i < 8; i++) host_write(3'(i), 32'h100 + 32'(i));
    chk("preload_word7", mem[7], 32'h107);

    // Play 2..4 once with word_ready held high: timing checked step by step.
    word_ready = 1'b1;
    start = 1'b1; start_addr = 3'd2; end_addr = 3'd4; loop_count = 8'd0;
    #1;
    chk1("p1_busy_before", busy, 1'b0);
    tick();
    start = 1'b0;
    chk1("p1_busy", busy, 1'b1);
    chk1("p1_fetch_valid", word_valid, 1'b0);
    chk("p1_rd_addr", 32'(la_read_address), 32'd2);
    tick();
    chk1("p1_w0_valid", word_valid, 1'b1);
    chk("p1_w0_data", word_data, 32'h102);
    chk1("p1_w0_last", word_last, 1'b0);
    tick();
    chk1("p1_gap0", word_valid, 1'b0);
    tick();
    chk("p1_w1_data", word_data, 32'h103);
    chk1("p1_w1_last", word_last, 1'b0);
    tick();
    tick();
    chk1("p1_w2_valid", word_valid, 1'b1);
    chk("p1_w2_data", word_data, 32'h104);
    chk1("p1_w2_last", word_last, 1'b1);
    tick();
    chk1("p1_done_busy", busy, 1'b0);
    chk1("p1_done_valid", word_valid, 1'b0);
    chk1("p1_done_last", word_last, 1'b0);

    // Wrapping program 6..1 with one extra pass (when looping is built in).
    exp_q = '{32'h106, 32'h107, 32'h100, 32'h101};
`ifdef PROG_LOOP_EN
    last_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_q.push_back(32'h106); exp_q.push_back(32'h107);
    exp_q.push_back(32'h100); exp_q.push_back(32'h101);
    last_q.push_back(1'b0); last_q.push_back(1'b0);
    last_q.push_back(1'b0); last_q.push_back(1'b1);
`else
    last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
    start = 1'b1; start_addr = 3'd6; end_addr = 3'd1; loop_count = 8'd1;
    tick();
    start = 1'b0;
    collect(60);
    chk1("p2_done_busy", busy, 1'b0);
    chk1("p2_done_valid", word_valid, 1'b0);

    // Host write to word 3 while it is being fetched: fetch stalls until write retires.
    word_ready = 1'b0; loop_count = 8'd0;
    host_wr_valid = 1'b1; host_wr_addr = 3'd3; host_wr_data = 32'hCAFE0003;
    start = 1'b1; start_addr = 3'd3; end_addr = 3'd3;
    tick();
    host_wr_valid = 1'b0; start = 1'b0;
    chk1("hz_setup_busy", busy, 1'b1);
    chk1("hz_setup_valid", word_valid, 1'b0);
    tick();
    chk1("hz_strobe_valid", word_valid, 1'b0);
    chk1("hz_strobe", la_write, 1'b1);
    tick();
    chk1("hz_hold_valid", word_valid, 1'b0);
    tick();
    chk1("hz_idle_valid", word_valid, 1'b0);
    chk("hz_rd_state", 32'(rd_state_dbg), 32'd1);
    tick();
    chk1("hz_present_valid", word_valid, 1'b1);
    chk("hz_present_data", word_data, 32'hCAFE0003);
    chk1("hz_present_last", word_last, 1'b1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk1("hz_done_busy", busy, 1'b0);

    // Back-pressure for five cycles, then stop alongside word_ready.
    start = 1'b1; start_addr = 3'd0; end_addr = 3'd1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", word_valid, 1'b1);
      chk("bp_data", word_data, 32'h100);
      tick();
    end
    stop = 1'b1; word_ready = 1'b1;
    tick();
    stop = 1'b0; word_ready = 1'b0;
    chk1("stop_valid", word_valid, 1'b0);
    chk1("stop_busy", busy, 1'b0);
    chk("stop_rd_state", 32'(rd_state_dbg), 32'd0);

    // start and stop in the same cycle: playback never begins.
    start = 1'b1; stop = 1'b1; start_addr = 3'd0; end_addr = 3'd0;
    tick();
    start = 1'b0; stop = 1'b0;
    chk1("ss_busy", busy, 1'b0);
    tick();
    chk1("ss_busy_later", busy, 1'b0);
    chk1("ss_valid_later", word_valid, 1'b0);

    // Reset during the strobe cycle drops the strobe on the next edge.
    host_wr_valid = 1'b1; host_wr_addr = 3'd6; host_wr_data = 32'h12345678;
    tick();
    host_wr_valid = 1'b0;
    tick();
    chk1("rs_strobe", la_write, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rs_ready_in_rst", host_wr_ready, 1'b0);
    tick();
    chk1("rs_strobe_dropped", la_write, 1'b0);
    chk("rs_wr_addr", 32'(la_write_address), 32'd0);
    chk("rs_wdata", la_wdata, 32'd0);
    rst = 1'b0;
    tick();
    chk1("rs_ready_after", host_wr_ready, 1'b1);
    chk("rs_wr_state", 32'(wr_state_dbg), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
